// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
//   Shared types and default parameters for the multiplier arbiter slice.
//   Contents:
//     NUM_REQ_DEF / DATA_W_DEF / LATENCY_DEF : default top-level parameters
//     NUM_REQ_MAX                            : largest supported requester count
//     req_id_t                               : requester index
//     tag_t                                  : {vld, id} entry of the tag pipe
// -----------------------------------------------------------------------------
package mult_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 27;
  localparam int LATENCY_DEF = 5;

  // The id type is sized for the largest supported NUM_REQ so that one package
  // serves every legal parameterisation of the top (2..8 requesters).
  localparam int NUM_REQ_MAX = 8;
  localparam int ID_W        = $clog2(NUM_REQ_MAX);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin search. Picks the first requesting index at or
//   after ptr_i, wrapping modulo NUM_REQ.
//   Ports:
//     req_i    : per-requester request (already qualified by the caller)
//     ptr_i    : highest-priority index this cycle (0..NUM_REQ-1)
//     gnt_o    : one-hot grant, zero when req_i is zero
//     gnt_id_o : index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_id_t            ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_id_t            gnt_id_o
);

  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic [ID_W:0]      pos;

  // Doubling the request vector lets a plain right shift act as a rotate, so
  // bit 0 of rot is the requester at ptr_i and the search is a fixed priority.
  // NOTE: always_comb uses blocking assignments and gives every output a
  // default first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    rot      = NUM_REQ'({req_i, req_i} >> ptr_i);
    found    = 1'b0;
    pos      = '0;
    gnt_id_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = {1'b0, ptr_i} + (ID_W+1)'(i);
      end
    end
    // Undo the rotation: ptr + offset, wrapped back into 0..NUM_REQ-1.
    if (pos >= (ID_W+1)'(NUM_REQ)) begin
      pos = pos - (ID_W+1)'(NUM_REQ);
    end
    gnt_id_o = pos[ID_W-1:0];
    gnt_o    = found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_o) : '0;
  end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one pipelined multiplier among NUM_REQ requesters. Round-robin issue
//   of at most one operand pair per enabled cycle; a tag pipe follows each issue
//   through the multiplier and returns the result to its owner LATENCY enabled
//   cycles later.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     en                      : global enable, shared with the multiplier
//     req                     : per-requester request, held until granted
//     req_dataa / req_datab   : packed operands, DATA_W bits per requester
//     gnt                     : one-hot combinational grant
//     mult_dataa / mult_datab : operands to the multiplier (0 when idle)
//     mult_result             : product from the multiplier
//     rsp_valid               : one-hot pulse to the owner of mult_result
//     rsp_data                : mult_result, broadcast
//   Optional (macro MULT_ARB_STATS_EN):
//     stat_gnt_cnt            : per-requester saturating grant count, 16b each
//     stat_wait_cnt           : saturating count of enabled cycles with a waiter
// -----------------------------------------------------------------------------
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataa,
  input  logic [NUM_REQ*DATA_W-1:0]   req_datab,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           mult_dataa,
  output logic [DATA_W-1:0]           mult_datab,
  input  logic [2*DATA_W-1:0]         mult_result,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [2*DATA_W-1:0]         rsp_data
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       stat_gnt_cnt,
  output logic [15:0]                 stat_wait_cnt
`endif
);

  logic [NUM_REQ-1:0] req_arb;
  req_id_t            gnt_id;
  logic               issue;
  req_id_t            ptr_q, ptr_d;
  tag_t               tag_q [LATENCY];

  // Reset is folded in so the grant is silent while rst_n is held low.
  assign req_arb = (en && rst_n) ? req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i    (req_arb),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign issue = |gnt;

  // Operand mux: one-hot select, all zero when nothing is granted.
  always_comb begin
    mult_dataa = '0;
    mult_datab = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mult_dataa = req_dataa[i*DATA_W +: DATA_W];
        mult_datab = req_datab[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt_id == req_id_t'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag pipe advances in lockstep with the multiplier pipeline (same en).
  // NOTE: unlike a data-only pipe, every stage is reset here because a stale
  // vld bit would produce a response for an operation discarded by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else if (en) begin
      tag_q[0] <= '{vld: issue, id: gnt_id};
      for (int k = 1; k < LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // The last stage is held while en is low, so the response simply
  // re-presents once en returns.
  always_comb begin
    rsp_valid = '0;
    if (tag_q[LATENCY-1].vld && en) begin
      rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_q[LATENCY-1].id;
    end
  end

  assign rsp_data = mult_result;

`ifdef MULT_ARB_STATS_EN
  logic [15:0] gnt_cnt_q [NUM_REQ];
  logic [15:0] wait_cnt_q;
  logic        any_wait;

  assign any_wait = en && |(req & ~gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_cnt_q[i] <= '0;
      end
      wait_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && gnt[i] && (gnt_cnt_q[i] != 16'hFFFF)) begin
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
        end
      end
      if (any_wait && (wait_cnt_q != 16'hFFFF)) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    stat_gnt_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_gnt_cnt[i*16 +: 16] = gnt_cnt_q[i];
    end
  end

  assign stat_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//   Directed vectors with hand-computed products. Each expected grant is
//   checked where it is issued; the expected response (owner, product, cycle)
//   is queued and a separate monitor pops and compares whenever rsp_valid is
//   seen. A behavioural LATENCY-stage multiplier closes the loop.
//   Build with +define+MULT_ARB_STATS_EN to include the statistics section.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 27;
  localparam int L = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   en;
  logic [N-1:0]           req;
  logic [N*W-1:0]         req_dataa;
  logic [N*W-1:0]         req_datab;
  logic [N-1:0]           gnt;
  logic [W-1:0]           mult_dataa;
  logic [W-1:0]           mult_datab;
  logic signed [2*W-1:0]  mult_result;
  logic [N-1:0]           rsp_valid;
  logic signed [2*W-1:0]  rsp_data;
`ifdef MULT_ARB_STATS_EN
  logic [N*16-1:0]        stat_gnt_cnt;
  logic [15:0]            stat_wait_cnt;
`endif

  mult_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .LATENCY (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .req_dataa   (req_dataa),
    .req_datab   (req_datab),
    .gnt         (gnt),
    .mult_dataa  (mult_dataa),
    .mult_datab  (mult_datab),
    .mult_result (mult_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_gnt_cnt  (stat_gnt_cnt),
    .stat_wait_cnt (stat_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared multiplier: L enabled stages, no reset.
  logic signed [2*W-1:0] mpipe [L];
  always @(posedge clk) begin
    if (en) begin
      mpipe[0] <= $signed(mult_dataa) * $signed(mult_datab);
      for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mult_result = mpipe[L-1];

  typedef struct {
    logic [N-1:0]          onehot;
    logic signed [2*W-1:0] prod;
    int                    due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every response against the head of the scoreboard and
  // flags an expected response that never arrives by its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (|rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
          check("rsp_data", 64'(rsp_data), 64'(e.prod));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        check("rsp_missing", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_op(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    req_dataa[i*W +: W] = a;
    req_datab[i*W +: W] = b;
  endtask

  // One cycle: drive en/req, check the grant, queue the expected response.
  task automatic drive(input logic e, input logic [N-1:0] r, input logic [N-1:0] g,
                       input logic signed [2*W-1:0] p, input int lat);
    @(posedge clk); #1;
    en  = e;
    req = r;
    @(negedge clk);
    check("gnt", 64'(gnt), 64'(g));
    if (g == '0) begin
      check("mult_dataa_idle", 64'(mult_dataa), 64'd0);
    end else begin
      sb.push_back('{onehot: g, prod: p, due: cyc + lat});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, '0, '0, '0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '1;
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mult_dataa", 64'(mult_dataa), 64'd0);
    check("rst_mult_datab", 64'(mult_datab), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    req   = '0;
  endtask

  localparam logic signed [2*W-1:0] P0  = 42;
  localparam logic signed [2*W-1:0] P1  = -45;
  localparam logic signed [2*W-1:0] P2  = -12;
  localparam logic signed [2*W-1:0] P3  = 100000000;
  localparam logic signed [2*W-1:0] PB3 = 54'sd4503599627370496;   // (-2^26)^2
  localparam logic signed [2*W-1:0] PB0 = -54'sd4503599560261632;  // (2^26-1)*(-2^26)

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    req       = '0;
    req_dataa = '0;
    req_datab = '0;
    set_op(0, 27'sd6, 27'sd7);
    set_op(1, -27'sd5, 27'sd9);
    set_op(2, 27'sd3, -27'sd4);
    set_op(3, -27'sd100000, -27'sd1000);

    do_reset();

    // Single requester, ptr=0 -> 3 afterwards.
    drive(1'b1, 4'b0100, 4'b0100, P2, L);
    idle(7);

    // Bring ptr to 0, then all four continuously.
    drive(1'b1, 4'b1000, 4'b1000, P3, L);
    drive(1'b1, 4'b1111, 4'b0001, P0, L);
    drive(1'b1, 4'b1111, 4'b0010, P1, L);
    drive(1'b1, 4'b1111, 4'b0100, P2, L);
    drive(1'b1, 4'b1111, 4'b1000, P3, L);
    drive(1'b1, 4'b1111, 4'b0001, P0, L);
    drive(1'b1, 4'b1111, 4'b0010, P1, L);
    drive(1'b1, 4'b1111, 4'b0100, P2, L);
    drive(1'b1, 4'b1111, 4'b1000, P3, L);
    idle(7);

    // en stall early in flight: issue at t, en low t+2..t+4 -> response at t+8.
    drive(1'b1, 4'b0010, 4'b0010, P1, 8);
    drive(1'b1, 4'b0000, 4'b0000, '0, 0);
    repeat (3) drive(1'b0, 4'b1111, 4'b0000, '0, 0);
    idle(5);

    // en stall while the result sits in the last stage: en low t+5..t+6.
    drive(1'b1, 4'b0100, 4'b0100, P2, 7);
    idle(4);
    repeat (2) drive(1'b0, 4'b0000, 4'b0000, '0, 0);
    idle(3);

    // Mid-flight reset: ptr=3 gives 3,0,1; reset must discard them and ptr.
    drive(1'b1, 4'b1111, 4'b1000, P3, L);
    drive(1'b1, 4'b1111, 4'b0001, P0, L);
    drive(1'b1, 4'b1111, 4'b0010, P1, L);
    do_reset();
    drive(1'b1, 4'b1111, 4'b0001, P0, L);
    idle(7);

    // Sparse requesters with ptr=1, extreme operands.
    set_op(0, 27'sd67108863, -27'sd67108864);
    set_op(3, -27'sd67108864, -27'sd67108864);
    drive(1'b1, 4'b1001, 4'b1000, PB3, L);
    drive(1'b1, 4'b1001, 4'b0001, PB0, L);
    drive(1'b1, 4'b1001, 4'b1000, PB3, L);
    drive(1'b1, 4'b1001, 4'b0001, PB0, L);
    idle(7);

`ifdef MULT_ARB_STATS_EN
    do_reset();
    drive(1'b1, 4'b0011, 4'b0001, PB0, L);  // requester 1 waits one cycle
    for (int i = 0; i < 70000; i++) drive(1'b1, 4'b0010, 4'b0010, P1, L);
    idle(7);
    check("stat_gnt0", 64'(stat_gnt_cnt[15:0]), 64'd1);
    check("stat_gnt1", 64'(stat_gnt_cnt[31:16]), 64'hFFFF);
    check("stat_gnt2", 64'(stat_gnt_cnt[47:32]), 64'd0);
    check("stat_gnt3", 64'(stat_gnt_cnt[63:48]), 64'd0);
    check("stat_wait", 64'(stat_wait_cnt), 64'd1);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
